// File: rtl/float_op_seq_if.sv
// Bundle of the upstream request, float_op, downstream result and counter signals
// for float_op_seq. master = the sequencer, slave = its environment.
interface float_op_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_sub;
    logic        op_start;
    logic [31:0] op_x;
    logic [31:0] op_y;
    logic [31:0] op_sum;
    logic        op_valid;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_err;
    logic [15:0] done_cnt;
    logic [7:0]  err_cnt;

    modport master (
        input  in_valid, in_a, in_b, in_sub, op_sum, op_valid, out_ready,
        output in_ready, op_start, op_x, op_y, out_valid, out_data, out_err,
        done_cnt, err_cnt
    );

    modport slave (
        output in_valid, in_a, in_b, in_sub, op_sum, op_valid, out_ready,
        input  in_ready, op_start, op_x, op_y, out_valid, out_data, out_err,
        done_cnt, err_cnt
    );
endinterface

// File: rtl/float_op_seq.sv
// Sequencer in front of the float_op add/sub unit: accepts a request, issues a start
// pulse, waits for a completion edge or timeout, and holds the result until consumed.
module float_op_seq #(
    parameter int TIMEOUT = 64
) (
    input  logic           clk,
    input  logic           rst,
    float_op_seq_if.master bus,
    output logic [1:0]     state_o
);
    // Handshakes: a request moves on in_valid & in_ready, a result on out_valid & out_ready.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [31:0] TIMEOUT_NAN = 32'h7FC0_0000;
    localparam logic [15:0] TIMER_LAST  = 16'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        in_ready_q, in_ready_d;
    logic        op_start_q, op_start_d;
    logic [31:0] op_x_q, op_x_d;
    logic [31:0] op_y_q, op_y_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_data_q, out_data_d;
    logic        out_err_q, out_err_d;
    logic [15:0] done_cnt_q, done_cnt_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic [15:0] timer_q, timer_d;
    logic        op_valid_q;
    logic        op_edge;
    logic        timed_out;

    // Only a fresh rise counts, so a level left high by the previous job cannot complete this one.
    assign op_edge   = bus.op_valid & ~op_valid_q;
    assign timed_out = (timer_q == TIMER_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            op_start_q  <= 1'b0;
            op_x_q      <= '0;
            op_y_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_err_q   <= 1'b0;
            done_cnt_q  <= '0;
            err_cnt_q   <= '0;
            timer_q     <= '0;
            op_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            op_start_q  <= op_start_d;
            op_x_q      <= op_x_d;
            op_y_q      <= op_y_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_err_q   <= out_err_d;
            done_cnt_q  <= done_cnt_d;
            err_cnt_q   <= err_cnt_d;
            timer_q     <= timer_d;
            op_valid_q  <= bus.op_valid;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.in_valid) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (op_edge || timed_out) state_d = S_DONE;
            S_DONE:  if (bus.out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Flag outputs are decoded from the next state so they register in step with it.
    always_comb begin
        in_ready_d  = (state_d == S_IDLE);
        op_start_d  = (state_d == S_ISSUE);
        out_valid_d = (state_d == S_DONE);
        op_x_d      = op_x_q;
        op_y_d      = op_y_q;
        out_data_d  = out_data_q;
        out_err_d   = out_err_q;
        done_cnt_d  = done_cnt_q;
        err_cnt_d   = err_cnt_q;
        timer_d     = timer_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    op_x_d = bus.in_a;
                    op_y_d = bus.in_sub ? {~bus.in_b[31], bus.in_b[30:0]} : bus.in_b;
                end
            end
            S_ISSUE: timer_d = '0;
            S_WAIT: begin
                timer_d = timer_q + 16'd1;
                if (op_edge) begin
                    out_data_d = bus.op_sum;
                    out_err_d  = 1'b0;
                end else if (timed_out) begin
                    out_data_d = TIMEOUT_NAN;
                    out_err_d  = 1'b1;
                    if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
                end
            end
            S_DONE: if (bus.out_ready) done_cnt_d = done_cnt_q + 16'd1;
            default: ;
        endcase
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.op_start  = op_start_q;
    assign bus.op_x      = op_x_q;
    assign bus.op_y      = op_y_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_err   = out_err_q;
    assign bus.done_cnt  = done_cnt_q;
    assign bus.err_cnt   = err_cnt_q;
    assign state_o       = state_q;
endmodule

// File: tb/tb_float_op_seq.sv
// Bench for float_op_seq: a behavioural responder drives float_op's side and a
// reference model predicts completion cycle, result word and counters.
module tb_float_op_seq;
  localparam int TIMEOUT = 64;
  localparam logic [31:0] NAN_W = 32'h7FC0_0000;

  logic clk;
  logic rst;
  logic [1:0] dbg_state;
  int total;
  int bad;
  logic [31:0] exp_q[$];
  logic [15:0] exp_done;
  int exp_err;

  float_op_seq_if bus();

  float_op_seq #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .state_o(dbg_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // op_valid level the responder presents for sampling at the k-th edge of WAIT
  function automatic logic vsample(input int k, input logic lvl0, input int rise_at,
                                   input int drop_at);
    if (rise_at > 0 && k >= rise_at) return 1'b1;
    if (drop_at > 0 && k >= drop_at) return 1'b0;
    return lvl0;
  endfunction

  task automatic run_txn(input logic [31:0] a, input logic [31:0] b, input logic sub,
                         input logic [31:0] sum, input int rise_at, input int drop_at,
                         input bit keep_high, input int hold);
    logic [31:0] exp_y, exp_d;
    logic exp_e, lvl0, v, v_prev;
    int exp_k, got_k;
    bit extra_start;
    exp_y = sub ? (b ^ 32'h8000_0000) : b;
    lvl0 = bus.op_valid;
    exp_k = 0;
    v_prev = lvl0;
    for (int i = 1; i <= TIMEOUT; i++) begin
      v = vsample(i, lvl0, rise_at, drop_at);
      if (exp_k == 0 && v && !v_prev) exp_k = i;
      v_prev = v;
    end
    if (exp_k == 0) begin
      exp_k = TIMEOUT;
      exp_d = NAN_W;
      exp_e = 1'b1;
      if (exp_err < 255) exp_err++;
    end else begin
      exp_d = sum;
      exp_e = 1'b0;
    end
    exp_q.push_back(exp_d);

    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL in_ready_idle got=%b exp=1", bus.in_ready);
    end
    bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b; bus.in_sub = sub; bus.op_sum = sum;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.in_a = $urandom; bus.in_b = $urandom; bus.in_sub = 1'($urandom);
    total++;
    if ({bus.op_start, bus.in_ready, bus.out_valid} !== 3'b100) begin
      bad++; $display("FAIL issue_flags got=%b exp=100", {bus.op_start, bus.in_ready, bus.out_valid});
    end
    total++;
    if ({bus.op_x, bus.op_y} !== {a, exp_y}) begin
      bad++; $display("FAIL operands got=%h/%h exp=%h/%h", bus.op_x, bus.op_y, a, exp_y);
    end
    @(posedge clk); #1;
    total++;
    if (bus.op_start !== 1'b0) begin
      bad++; $display("FAIL start_single got=%b exp=0", bus.op_start);
    end
    got_k = 0;
    extra_start = 1'b0;
    for (int k = 1; k <= TIMEOUT + 4; k++) begin
      bus.op_valid = vsample(k, lvl0, rise_at, drop_at);
      @(posedge clk); #1;
      if (bus.op_start !== 1'b0) extra_start = 1'b1;
      if (bus.out_valid === 1'b1) begin
        got_k = k;
        break;
      end
    end
    total++;
    if (got_k != exp_k) begin
      bad++; $display("FAIL completion_cycle got=%0d exp=%0d", got_k, exp_k);
      void'(exp_q.pop_front());
      return;
    end
    total++;
    if (extra_start) begin
      bad++; $display("FAIL start_in_wait got=1 exp=0");
    end
    exp_d = exp_q.pop_front();
    total++;
    if ({bus.out_data, bus.out_err} !== {exp_d, exp_e}) begin
      bad++; $display("FAIL result got=%h/%b exp=%h/%b", bus.out_data, bus.out_err, exp_d, exp_e);
    end
    total++;
    if (bus.err_cnt !== 8'(exp_err)) begin
      bad++; $display("FAIL err_cnt got=%0d exp=%0d", bus.err_cnt, exp_err);
    end
    total++;
    if ({bus.op_x, bus.op_y} !== {a, exp_y}) begin
      bad++; $display("FAIL operand_hold got=%h/%h exp=%h/%h", bus.op_x, bus.op_y, a, exp_y);
    end
    if (!keep_high) bus.op_valid = 1'b0;
    for (int h = 0; h < hold; h++) begin
      bus.out_ready = 1'b0;
      bus.in_valid = 1'($urandom);
      bus.op_valid = 1'($urandom);
      bus.op_sum = $urandom;
      @(posedge clk); #1;
      total++;
      if ({bus.out_valid, bus.in_ready, bus.op_start, bus.out_err, bus.out_data} !==
          {3'b100, exp_e, exp_d}) begin
        bad++;
        $display("FAIL backpressure_hold got=%b%b%b/%b/%h exp=100/%b/%h", bus.out_valid,
                 bus.in_ready, bus.op_start, bus.out_err, bus.out_data, exp_e, exp_d);
      end
    end
    bus.in_valid = 1'b0;
    bus.op_valid = keep_high;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    exp_done++;
    total++;
    if ({bus.out_valid, bus.in_ready, bus.done_cnt} !== {2'b01, exp_done}) begin
      bad++;
      $display("FAIL release got=%b%b/%0d exp=01/%0d", bus.out_valid, bus.in_ready,
               bus.done_cnt, exp_done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_sub = 1'b0;
    bus.op_sum = '0; bus.op_valid = 1'b0; bus.out_ready = 1'b0;
    exp_done = '0; exp_err = 0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({bus.in_ready, bus.op_start, bus.out_valid, bus.out_err} !== 4'b1000) begin
      bad++; $display("FAIL reset_flags got=%b exp=1000",
                      {bus.in_ready, bus.op_start, bus.out_valid, bus.out_err});
    end
    total++;
    if ({bus.op_x, bus.op_y, bus.out_data, bus.done_cnt, bus.err_cnt} !== 120'd0) begin
      bad++; $display("FAIL reset_words got=%h/%h/%h/%0d/%0d exp=0", bus.op_x, bus.op_y,
                      bus.out_data, bus.done_cnt, bus.err_cnt);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_release got=%b exp=1", bus.in_ready);
    end
  endtask

  task automatic test_add();
    run_txn(32'h43E1_0CCD, 32'h4143_3333, 1'b0, 32'h43E7_2666, 5, 0, 1'b0, 0);
  endtask

  task automatic test_sub();
    run_txn(32'h43E1_0CCD, 32'h4143_3333, 1'b1, 32'h43DA_F334, 3, 0, 1'b0, 0);
    run_txn(32'h3F80_0000, 32'h8000_0000, 1'b1, 32'h3F80_0000, 1, 0, 1'b0, 0);
  endtask

  task automatic test_timeout();
    run_txn($urandom, $urandom, 1'b0, $urandom, 0, 0, 1'b0, 0);
    for (int i = 0; i < 300; i++)
      run_txn($urandom, $urandom, 1'($urandom), $urandom, 0, 0, 1'b0, 0);
  endtask

  task automatic test_level_valid();
    run_txn($urandom, $urandom, 1'b0, $urandom, 2, 0, 1'b1, 0);
    run_txn($urandom, $urandom, 1'b0, $urandom, 5, 0, 1'b1, 0);
    run_txn($urandom, $urandom, 1'b1, 32'h1234_5678, TIMEOUT, 10, 1'b0, 0);
  endtask

  task automatic test_backpressure();
    run_txn($urandom, $urandom, 1'b0, 32'hCAFE_F00D, 4, 0, 1'b0, 10);
    run_txn($urandom, $urandom, 1'b1, $urandom, 0, 0, 1'b0, 10);
  endtask

  task automatic test_reset_mid_wait();
    bus.in_valid = 1'b1; bus.in_a = $urandom; bus.in_b = $urandom; bus.in_sub = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    total++;
    if ({bus.in_ready, bus.op_start, bus.out_valid, bus.out_err} !== 4'b1000) begin
      bad++; $display("FAIL async_reset_flags got=%b exp=1000",
                      {bus.in_ready, bus.op_start, bus.out_valid, bus.out_err});
    end
    total++;
    if ({bus.op_x, bus.op_y, bus.out_data, bus.done_cnt, bus.err_cnt} !== 120'd0) begin
      bad++; $display("FAIL async_reset_words got=%h/%h/%h/%0d/%0d exp=0", bus.op_x, bus.op_y,
                      bus.out_data, bus.done_cnt, bus.err_cnt);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    exp_done = '0;
    exp_err = 0;
    exp_q.delete();
    run_txn(32'h4000_0000, 32'h3F80_0000, 1'b1, 32'h3F80_0000, 6, 0, 1'b0, 2);
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++)
      run_txn($urandom, $urandom, 1'($urandom), $urandom, $urandom_range(0, TIMEOUT + 3),
              0, 1'b0, $urandom_range(0, 3));
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_add();
    test_sub();
    test_timeout();
    test_level_valid();
    test_backpressure();
    test_reset_mid_wait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
